// File: rtl/mem_indirect_pkg.sv
// Shared register map, OP encodings and controller state encoding for the
// indirect-access memory sequencer.
package mem_indirect_pkg;

  localparam int OP_REG            = 3;
  localparam int INDIRECT_ADDR_REG = 4;
  localparam int INDIRECT_DATA_REG = 5;
  localparam int RDDATA_REG        = 6;

  typedef enum logic [1:0] {
    NOP = 2'b00,
    RD  = 2'b01,
    WR  = 2'b10
  } op_t;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_IDLE,
    ST_SET_ADDR,
    ST_SET_DATA,
    ST_SET_OP_WR,
    ST_SET_OP_RD,
    ST_SETTLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_CLR_OP,
    ST_RESP
  } state_t;

endpackage

// File: rtl/mem_indirect_ctrl.sv
// Turns single-word host read/write requests into the register-level
// INDIRECT_ADDR / INDIRECT_DATA / OP / RDDATA bus sequence of the memory block.
module mem_indirect_ctrl
  import mem_indirect_pkg::*;
#(
  parameter int DWIDTH          = 8,
  parameter int AWIDTH          = 8,
  parameter int INDIRECT_AWIDTH = 8,
  parameter int SETTLE_CYCLES   = 1,
  parameter int RD_TIMEOUT      = 16
) (
  input  logic                       clk_i,
  input  logic                       arst_n_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_we_i,
  input  logic [INDIRECT_AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0]          req_wdata_i,
  output logic                       rsp_valid_o,
  output logic [DWIDTH-1:0]          rsp_rdata_o,
  output logic                       rsp_err_o,
  output logic                       busy_o,
  output logic [AWIDTH-1:0]          bus_addr_o,
  output logic                       bus_wr_o,
  output logic                       bus_rd_o,
  output logic [DWIDTH-1:0]          bus_wdata_o,
  input  logic [DWIDTH-1:0]          bus_rddata_i,
  input  logic                       bus_rddatavalid_i,
  output logic [3:0]                 state_o
);

  localparam int TO_W  = $clog2(RD_TIMEOUT + 1);
  localparam int CNT_W = (TO_W > 4) ? TO_W : 4;

  state_t             state;
  logic               we_q;
  logic [DWIDTH-1:0]  wdata_q;
  logic [DWIDTH-1:0]  rdata_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt;

  assign state_o = state;

  // Request port: a transfer happens on a cycle where req_valid_i and
  // req_ready_o are both high; ready is only offered in IDLE, so the payload
  // is sampled exactly once per request and nothing is queued.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state       <= ST_INIT;
      req_ready_o <= 1'b0;
      busy_o      <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      bus_addr_o  <= '0;
      bus_wr_o    <= 1'b0;
      bus_rd_o    <= 1'b0;
      bus_wdata_o <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt         <= '0;
    end else begin
      // Strobes are single-cycle; address/data read as zero when idle.
      bus_wr_o    <= 1'b0;
      bus_rd_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      case (state)
        ST_INIT: begin
          // An OP left at WR/RD by a reset mid-operation is cleared first.
          bus_wr_o    <= 1'b1;
          bus_addr_o  <= AWIDTH'(OP_REG);
          bus_wdata_o <= DWIDTH'(NOP);
          state       <= ST_IDLE;
        end
        ST_IDLE: begin
          if (req_valid_i && req_ready_o) begin
            we_q        <= req_we_i;
            wdata_q     <= req_wdata_i;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            bus_wr_o    <= 1'b1;
            bus_addr_o  <= AWIDTH'(INDIRECT_ADDR_REG);
            bus_wdata_o <= DWIDTH'(req_addr_i);
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            state       <= ST_SET_ADDR;
          end else begin
            req_ready_o <= 1'b1;
          end
        end
        ST_SET_ADDR: begin
          bus_wr_o <= 1'b1;
          if (we_q) begin
            bus_addr_o  <= AWIDTH'(INDIRECT_DATA_REG);
            bus_wdata_o <= wdata_q;
            state       <= ST_SET_DATA;
          end else begin
            bus_addr_o  <= AWIDTH'(OP_REG);
            bus_wdata_o <= DWIDTH'(RD);
            state       <= ST_SET_OP_RD;
          end
        end
        ST_SET_DATA: begin
          bus_wr_o    <= 1'b1;
          bus_addr_o  <= AWIDTH'(OP_REG);
          bus_wdata_o <= DWIDTH'(WR);
          state       <= ST_SET_OP_WR;
        end
        ST_SET_OP_WR: begin
          bus_wr_o    <= 1'b1;
          bus_addr_o  <= AWIDTH'(OP_REG);
          bus_wdata_o <= DWIDTH'(NOP);
          state       <= ST_CLR_OP;
        end
        ST_SET_OP_RD: begin
          cnt   <= '0;
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            bus_rd_o   <= 1'b1;
            bus_addr_o <= AWIDTH'(RDDATA_REG);
            state      <= ST_RD_ISSUE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RD_ISSUE: begin
          cnt   <= '0;
          state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          // Valid on the cycle the counter reaches RD_TIMEOUT still wins.
          if (bus_rddatavalid_i || cnt == CNT_W'(RD_TIMEOUT)) begin
            rdata_q     <= bus_rddatavalid_i ? bus_rddata_i : '0;
            err_q       <= !bus_rddatavalid_i;
            bus_wr_o    <= 1'b1;
            bus_addr_o  <= AWIDTH'(OP_REG);
            bus_wdata_o <= DWIDTH'(NOP);
            state       <= ST_CLR_OP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_CLR_OP: begin
          rsp_valid_o <= 1'b1;
          rsp_rdata_o <= rdata_q;
          rsp_err_o   <= err_q;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          req_ready_o <= 1'b1;
          busy_o      <= 1'b0;
          state       <= ST_IDLE;
        end
        default: begin
          req_ready_o <= 1'b0;
          busy_o      <= 1'b0;
          state       <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_indirect_ctrl.sv
// Directed plus randomized bench for mem_indirect_ctrl with an indirect
// memory device model and a request-level reference of bus sequences.
module tb_mem_indirect_ctrl;

  localparam int DW     = 8;
  localparam int AW     = 8;
  localparam int IAW    = 8;
  localparam int SETTLE = 1;
  localparam int RT     = 16;
  localparam int SW     = 2 + AW + DW + 8;

  logic           clk_i = 1'b0;
  logic           arst_n_i = 1'b0;
  logic           req_valid_i = 1'b0;
  logic           req_ready_o;
  logic           req_we_i = 1'b0;
  logic [IAW-1:0] req_addr_i = '0;
  logic [DW-1:0]  req_wdata_i = '0;
  logic           rsp_valid_o;
  logic [DW-1:0]  rsp_rdata_o;
  logic           rsp_err_o;
  logic           busy_o;
  logic [AW-1:0]  bus_addr_o;
  logic           bus_wr_o;
  logic           bus_rd_o;
  logic [DW-1:0]  bus_wdata_o;
  logic [DW-1:0]  bus_rddata_i;
  logic           bus_rddatavalid_i;
  logic [3:0]     state_o;

  mem_indirect_ctrl #(
    .DWIDTH(DW), .AWIDTH(AW), .INDIRECT_AWIDTH(IAW),
    .SETTLE_CYCLES(SETTLE), .RD_TIMEOUT(RT)
  ) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .busy_o(busy_o), .bus_addr_o(bus_addr_o), .bus_wr_o(bus_wr_o),
    .bus_rd_o(bus_rd_o), .bus_wdata_o(bus_wdata_o),
    .bus_rddata_i(bus_rddata_i), .bus_rddatavalid_i(bus_rddatavalid_i),
    .state_o(state_o)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int hs_cyc = 0;
  int rsp_cyc = 0;
  bit hold_valid = 1'b0;
  bit stray = 1'b0;
  int rd_delay = 0;
  int rd_cd = -1;

  logic [DW-1:0]  ref_mem [256];
  logic [DW-1:0]  dev_mem [256];
  logic [SW-1:0]  exp_q [$];
  logic [SW-1:0]  obs_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SW-1:0] ent(input bit rd, input bit wr, input int a, input int d, input int rel);
    logic [AW-1:0] aa = AW'(a);
    logic [DW-1:0] dd = DW'(d);
    logic [7:0]    rr = 8'(rel);
    return {rd, wr, aa, dd, rr};
  endfunction

  // ---------------- bus monitor ----------------
  always @(negedge clk_i) begin
    if (bus_wr_o || bus_rd_o) begin
      check("strobe_excl", 32'(bus_wr_o & bus_rd_o), 32'd0);
      obs_q.push_back({bus_rd_o, bus_wr_o, bus_addr_o, bus_wdata_o, 8'(cyc - hs_cyc)});
    end else begin
      check("idle_bus", {bus_addr_o, bus_wdata_o}, 32'd0);
    end
    if (!rsp_valid_o) check("rsp_idle", {rsp_err_o, rsp_rdata_o}, 32'd0);
  end

  // ---------------- indirect memory device model ----------------
  initial begin : device
    logic [DW-1:0] ia, id, rv;
    ia = '0; id = '0; rv = '0;
    bus_rddatavalid_i = 1'b0;
    bus_rddata_i = '0;
    forever begin
      @(negedge clk_i);
      bus_rddatavalid_i = 1'b0;
      bus_rddata_i = '0;
      if (stray) begin
        bus_rddatavalid_i = 1'b1;
        bus_rddata_i = DW'($urandom);
      end
      if (rd_cd == 0) begin
        bus_rddatavalid_i = 1'b1;
        bus_rddata_i = rv;
      end
      if (rd_cd >= 0) rd_cd--;
      if (bus_wr_o) begin
        case (int'(bus_addr_o))
          4: ia = bus_wdata_o;
          5: id = bus_wdata_o;
          3: if (bus_wdata_o == DW'(2)) dev_mem[ia] = id;
          default: ;
        endcase
      end
      if (bus_rd_o && bus_addr_o == AW'(6)) begin
        rv = dev_mem[ia];
        if (rd_delay >= 0) rd_cd = rd_delay;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_init();
    check("init_op_wr", {bus_wr_o, bus_rd_o, bus_addr_o, bus_wdata_o, req_ready_o},
          {1'b1, 1'b0, 8'd3, 8'd0, 1'b0});
    @(negedge clk_i);
    check("init_ready", {req_ready_o, busy_o, bus_wr_o, bus_rd_o, rsp_valid_o}, 32'b10000);
    obs_q.delete();
  endtask

  task automatic wait_hs();
    bit got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready_o) begin
        got = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    check("hs_seen", 32'(got), 32'd1);
    hs_cyc = cyc;
  endtask

  // Expected behaviour comes from the request alone: bus sequence with
  // relative cycle stamps, latency and response fields.
  task automatic run_req(input bit we, input int a, input int d, input int dly);
    logic [DW-1:0] exp_rd;
    bit exp_err, got;
    int lat, m;
    req_we_i = we;
    req_addr_i = IAW'(a);
    req_wdata_i = DW'(d);
    req_valid_i = 1'b1;
    rd_delay = dly;
    wait_hs();
    @(negedge clk_i);
    req_valid_i = hold_valid;
    exp_q.push_back(ent(0, 1, 4, a, 1));
    if (we) begin
      exp_q.push_back(ent(0, 1, 5, d, 2));
      exp_q.push_back(ent(0, 1, 3, 2, 3));
      exp_q.push_back(ent(0, 1, 3, 0, 4));
      lat = 5;
      exp_rd = '0;
      exp_err = 1'b0;
      ref_mem[a] = DW'(d);
    end else begin
      exp_err = (dly < 0) || (dly > RT);
      m = exp_err ? RT : dly;
      exp_q.push_back(ent(0, 1, 3, 1, 2));
      exp_q.push_back(ent(1, 0, 6, 0, 3 + SETTLE));
      exp_q.push_back(ent(0, 1, 3, 0, 5 + SETTLE + m));
      lat = 6 + SETTLE + m;
      exp_rd = exp_err ? '0 : ref_mem[a];
    end
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid_o) begin
        got = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    check("rsp_seen", 32'(got), 32'd1);
    rsp_cyc = cyc;
    if (got) begin
      check("latency", cyc - hs_cyc, lat);
      check("rsp_rdata", 32'(rsp_rdata_o), 32'(exp_rd));
      check("rsp_err", 32'(rsp_err_o), 32'(exp_err));
    end
    check("bus_count", obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check("bus_seq", 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
    obs_q.delete();
    exp_q.delete();
    @(negedge clk_i);
    check("rsp_one_cycle", 32'(rsp_valid_o), 32'd0);
  endtask

  // ---------------- stimulus sequence ----------------
  initial begin : main
    int prev, sel, dly;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = DW'($urandom);
      dev_mem[i] = ref_mem[i];
    end
    ref_mem[8'h12] = 8'h3C;
    dev_mem[8'h12] = 8'h3C;

    arst_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_outputs", {req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o,
                          bus_addr_o, bus_wr_o, bus_rd_o, bus_wdata_o}, 32'd0);
    arst_n_i = 1'b1;
    @(negedge clk_i);
    check_init();

    run_req(0, 8'h12, 0, 0);          // read returns seeded 0x3C
    run_req(1, 8'h12, 8'hA5, 0);
    run_req(0, 8'h12, 0, 0);
    run_req(0, 8'h12, 0, -1);         // no valid ever: timeout
    run_req(0, 8'h33, 0, RT);         // valid exactly at the limit
    run_req(0, 8'h34, 0, RT + 1);     // one cycle too late

    stray = 1'b1;
    run_req(1, 8'h80, 8'h5E, 0);
    stray = 1'b0;
    run_req(0, 8'h80, 0, 3);

    hold_valid = 1'b1;
    run_req(1, 8'h20, 8'h5A, 0);
    hold_valid = 1'b0;
    prev = rsp_cyc;
    run_req(0, 8'h20, 0, 0);
    check("b2b_hs", hs_cyc, prev + 1);

    // Reset pulsed while OP=WR is on the bus.
    req_we_i = 1'b1;
    req_addr_i = 8'h55;
    req_wdata_i = 8'h77;
    req_valid_i = 1'b1;
    wait_hs();
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #2 arst_n_i = 1'b0;
    #1 check("async_rst", {req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o,
                           bus_addr_o, bus_wr_o, bus_rd_o, bus_wdata_o}, 32'd0);
    @(negedge clk_i);
    obs_q.delete();
    @(negedge clk_i);
    arst_n_i = 1'b1;
    @(negedge clk_i);
    check_init();
    run_req(0, 8'h55, 0, 1);

    for (int n = 0; n < 24; n++) begin
      sel = $urandom_range(0, 9);
      dly = (sel == 0) ? -1 : (sel == 1) ? RT : (sel == 2) ? RT + 1 : $urandom_range(0, 6);
      run_req(1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom_range(0, 255), dly);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete, observed time %0t", $time);
    $fatal(1);
  end

endmodule
